// File: rtl/ahbl_wrap4_master_if.sv
// Line-request/response and AHB-Lite master signals of ahbl_wrap4_master.
// The master modport is the initiator's view; the slave modport is the
// requester/bus-slave environment's view.
interface ahbl_wrap4_master_if #(
  parameter int W_HADDR = 32,
  parameter int W_HDATA = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [W_HADDR-1:0] req_addr;
  logic [127:0]       req_wdata;
  logic               rsp_valid;
  logic [127:0]       rsp_rdata;
  logic               rsp_err;

  logic [W_HADDR-1:0] ahblm_haddr;
  logic               ahblm_hwrite;
  logic [1:0]         ahblm_htrans;
  logic [2:0]         ahblm_hsize;
  logic [2:0]         ahblm_hburst;
  logic [3:0]         ahblm_hprot;
  logic               ahblm_hmastlock;
  logic [W_HDATA-1:0] ahblm_hwdata;
  logic               ahblm_hready;
  logic               ahblm_hresp;
  logic [W_HDATA-1:0] ahblm_hrdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  ahblm_hready, ahblm_hresp, ahblm_hrdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
    output ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output ahblm_hready, ahblm_hresp, ahblm_hrdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
    input  ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );
endinterface

// File: rtl/ahbl_wrap4_master.sv
// AHB-Lite initiator: one 128-bit line request becomes a single WRAP4 burst of
// 32-bit words, critical word first, with one response pulse per request.
module ahbl_wrap4_master #(
  parameter int W_HADDR = 32,
  parameter int W_HDATA = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  ahbl_wrap4_master_if.master bus
);

  if (W_HDATA != 32) begin : g_bad_hdata
    $error("ahbl_wrap4_master supports W_HDATA == 32 only");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BURST = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ERR   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ  = 2'b11;

  logic [2:0]         r_state;
  logic               r_write;
  logic [1:0]         r_abeat;
  logic [1:0]         r_dbeat;
  logic               r_dvld;
  logic [W_HADDR-1:0] r_haddr;
  logic [1:0]         r_htrans;
  logic               r_hwrite;
  logic [2:0]         r_hsize;
  logic [2:0]         r_hburst;
  logic [W_HDATA-1:0] r_hwdata;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [127:0]       r_rsp_rdata;

  logic [W_HADDR-5:0] r_line;
  logic [1:0]         r_start;
  logic [127:0]       r_wline;
  logic [127:0]       r_cap;

  logic               w_ready;
  logic               w_accept;
  logic               w_active;
  logic               w_err1;
  logic               w_dcap;
  logic [1:0]         w_alane;
  logic [1:0]         w_anext;
  logic [1:0]         w_dlane;
  logic [127:0]       w_cap_nxt;

  assign w_ready  = (r_state == S_IDLE) && rst_n;
  assign w_accept = bus.req_valid && w_ready;
  assign w_active = (r_state == S_BURST) || (r_state == S_DRAIN);
  assign w_err1   = w_active && r_dvld && bus.ahblm_hresp && !bus.ahblm_hready;
  assign w_dcap   = w_active && r_dvld && bus.ahblm_hready && !bus.ahblm_hresp;
  assign w_alane  = r_start + r_abeat;
  assign w_anext  = r_start + r_abeat + 2'd1;
  assign w_dlane  = r_start + r_dbeat;

  // Lanes are indexed by address word, so beats land rotated by the start word.
  always_comb begin
    w_cap_nxt = r_cap;
    if (w_dcap) w_cap_nxt[{w_dlane, 5'd0} +: 32] = bus.ahblm_hrdata;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line  <= bus.req_addr[W_HADDR-1:4];
      r_start <= bus.req_addr[3:2];
      r_wline <= bus.req_wdata;
      r_cap   <= '0;
    end else begin
      r_cap   <= w_cap_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_abeat     <= 2'd0;
      r_dbeat     <= 2'd0;
      r_dvld      <= 1'b0;
      r_haddr     <= '0;
      r_htrans    <= HT_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'b000;
      r_hburst    <= 3'b000;
      r_hwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_BURST;
            r_write  <= bus.req_write;
            r_abeat  <= 2'd0;
            r_dvld   <= 1'b0;
            r_haddr  <= bus.req_addr & {{(W_HADDR-2){1'b1}}, 2'b00};
            r_htrans <= HT_NSEQ;
            r_hwrite <= bus.req_write;
            r_hsize  <= 3'b010;
            r_hburst <= 3'b010;
          end
        end
        S_BURST, S_DRAIN: begin
          // First ERROR cycle: drop to IDLE so the remaining beats are cancelled.
          if (w_err1) begin
            r_state  <= S_ERR;
            r_htrans <= HT_IDLE;
          end else if (bus.ahblm_hready) begin
            if (r_state == S_BURST) begin
              r_dvld   <= 1'b1;
              r_dbeat  <= r_abeat;
              r_hwdata <= r_wline[{w_alane, 5'd0} +: 32];
              if (r_abeat == 2'd3) begin
                r_state  <= S_DRAIN;
                r_htrans <= HT_IDLE;
              end else begin
                r_abeat  <= r_abeat + 2'd1;
                r_haddr  <= {r_line, w_anext, 2'b00};
                r_htrans <= HT_SEQ;
              end
            end else begin
              r_dvld      <= 1'b0;
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              if (!r_write) r_rsp_rdata <= w_cap_nxt;
            end
          end
        end
        S_ERR: begin
          if (bus.ahblm_hready && bus.ahblm_hresp) begin
            r_dvld      <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            if (!r_write) r_rsp_rdata <= r_cap;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = w_ready;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_err         = r_rsp_err;
  assign bus.rsp_rdata       = r_rsp_rdata;
  assign bus.ahblm_haddr     = r_haddr;
  assign bus.ahblm_hwrite    = r_hwrite;
  assign bus.ahblm_htrans    = r_htrans;
  assign bus.ahblm_hsize     = r_hsize;
  assign bus.ahblm_hburst    = r_hburst;
  assign bus.ahblm_hprot     = 4'b0011;
  assign bus.ahblm_hmastlock = 1'b0;
  assign bus.ahblm_hwdata    = r_hwdata;

endmodule

// File: tb/tb_ahbl_wrap4_master.sv
// Scoreboard bench for ahbl_wrap4_master: directed line requests against a
// small behavioural AHB-Lite slave with configurable wait states and errors.
module tb_ahbl_wrap4_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahbl_wrap4_master_if bus ();

  ahbl_wrap4_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [31:0] a; logic [1:0] t; logic w; } addr_t;
  typedef struct { logic [127:0] d; logic e; int lat; } rsp_t;

  addr_t       q_addr[$];
  logic [31:0] q_wd[$];
  rsp_t        q_rsp[$];
  int          q_acc[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_prev = 0;
  int acc_last = 0;
  int n_rsp_seen = 0;
  bit chk_en = 1'b1;

  logic [31:0] sl_rd [4];
  int          sl_err_beat = -1;
  int          sl_wait_beat = -1;
  int          sl_wait_n = 0;
  bit          dp_cur, dp_write;
  int          beat, wleft, err_st;
  logic        prev_hready;
  logic [1:0]  prev_htrans;
  logic        prev_hwrite;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: got no/extra event, want expected event", nm);
  endtask

  task automatic set_rd(input logic [31:0] b0, input logic [31:0] b1,
                        input logic [31:0] b2, input logic [31:0] b3);
    sl_rd[0] = b0; sl_rd[1] = b1; sl_rd[2] = b2; sl_rd[3] = b3;
  endtask

  // ea/ewd hold beat k in bits [32k+31:32k]; na = address phases expected.
  task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] wd,
                       input logic [127:0] ea, input int na, input logic [127:0] ewd,
                       input logic [127:0] erd, input logic ee, input int lat,
                       input bit expect_rsp);
    addr_t e;
    rsp_t  r;
    int    n;
    if (expect_rsp) begin
      for (int k = 0; k < na; k++) begin
        e.a = ea[32*k +: 32];
        e.t = (k == 0) ? 2'b10 : 2'b11;
        e.w = w;
        q_addr.push_back(e);
      end
      if (w) for (int k = 0; k < 4; k++) q_wd.push_back(ewd[32*k +: 32]);
      r.d = erd; r.e = ee; r.lat = lat;
      q_rsp.push_back(r);
    end
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      fail("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q_rsp.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q_rsp.size() != 0) begin
      fail("rsp_timeout");
      q_rsp.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Behavioural slave: decides hready/hresp/hrdata for the current cycle.
  initial begin
    bus.ahblm_hready = 1'b1;
    bus.ahblm_hresp  = 1'b0;
    bus.ahblm_hrdata = '0;
    dp_cur = 1'b0; dp_write = 1'b0; beat = 0; wleft = 0; err_st = 0;
    prev_hready = 1'b1; prev_htrans = 2'b00; prev_hwrite = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp_cur = 1'b0; err_st = 0;
        prev_hready = 1'b1; prev_htrans = 2'b00; prev_hwrite = 1'b0;
        bus.ahblm_hready = 1'b1;
        bus.ahblm_hresp  = 1'b0;
      end else begin
        if (prev_hready) begin
          dp_cur   = prev_htrans[1];
          dp_write = prev_hwrite;
          err_st   = 0;
          if (prev_htrans == 2'b10) begin
            beat  = 0;
            wleft = sl_wait_n;
          end else if (prev_htrans == 2'b11) begin
            beat++;
          end
        end
        bus.ahblm_hrdata = 32'hDEADBEEF;
        if (!dp_cur) begin
          bus.ahblm_hready = 1'b1; bus.ahblm_hresp = 1'b0;
        end else if (err_st == 1) begin
          bus.ahblm_hready = 1'b1; bus.ahblm_hresp = 1'b1; err_st = 2;
        end else if (beat == sl_err_beat) begin
          bus.ahblm_hready = 1'b0; bus.ahblm_hresp = 1'b1; err_st = 1;
        end else if (beat == sl_wait_beat && wleft > 0) begin
          bus.ahblm_hready = 1'b0; bus.ahblm_hresp = 1'b0; wleft--;
        end else begin
          bus.ahblm_hready = 1'b1; bus.ahblm_hresp = 1'b0;
          bus.ahblm_hrdata = sl_rd[beat];
        end
        prev_hready = bus.ahblm_hready;
        prev_htrans = bus.ahblm_htrans;
        prev_hwrite = bus.ahblm_hwrite;
      end
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        q_acc.delete();
      end else begin
        if (bus.req_valid && bus.req_ready) begin
          q_acc.push_back(cyc);
          acc_prev = acc_last;
          acc_last = cyc;
        end
        if (chk_en && bus.ahblm_htrans != 2'b00) begin
          if (q_addr.size() == 0) fail("unexpected_addr_phase");
          else begin
            chk("haddr", bus.ahblm_haddr, q_addr[0].a);
            chk("htrans", bus.ahblm_htrans, q_addr[0].t);
            chk("hwrite", bus.ahblm_hwrite, q_addr[0].w);
            chk("hctrl", {bus.ahblm_hsize, bus.ahblm_hburst, bus.ahblm_hprot, bus.ahblm_hmastlock},
                {3'b010, 3'b010, 4'b0011, 1'b0});
            if (bus.ahblm_hready) void'(q_addr.pop_front());
          end
        end
        if (bus.ahblm_hresp && bus.ahblm_hready)
          chk("htrans_err2", bus.ahblm_htrans, 2'b00);
        if (chk_en && dp_cur && dp_write) begin
          if (q_wd.size() == 0) fail("unexpected_wdata");
          else begin
            chk("hwdata", bus.ahblm_hwdata, q_wd[0]);
            if (bus.ahblm_hready) void'(q_wd.pop_front());
          end
        end
        if (bus.rsp_valid) begin
          n_rsp_seen++;
          if (q_rsp.size() == 0) fail("unexpected_rsp");
          else begin
            r = q_rsp.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, r.d);
            chk("rsp_err", bus.rsp_err, r.e);
            if (q_acc.size() == 0) fail("rsp_without_accept");
            else chk("rsp_latency", cyc - q_acc.pop_front(), r.lat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line_b2b;
    int           n_before;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    set_rd(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_htrans", bus.ahblm_htrans, 2'b00);
    chk("rst_haddr", bus.ahblm_haddr, 32'h0);
    chk("rst_hprot", bus.ahblm_hprot, 4'b0011);
    chk("rst_hctrl", {bus.ahblm_hwrite, bus.ahblm_hsize, bus.ahblm_hburst, bus.ahblm_hmastlock}, 8'h00);
    chk("rst_hwdata", bus.ahblm_hwdata, 32'h0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b00);
    chk("rst_rsp_rdata", bus.rsp_rdata, 128'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_reset", bus.req_ready, 1'b1);

    // Write, unaligned start word 2
    issue(1'b1, 32'h0000_0108, 128'h44444444_33333333_22222222_11111111,
          {32'h104, 32'h100, 32'h10C, 32'h108}, 4,
          {32'h22222222, 32'h11111111, 32'h44444444, 32'h33333333},
          128'h0, 1'b0, 6, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();

    // Read wrapping from word 3
    set_rd(32'hA, 32'hB, 32'hC, 32'hD);
    issue(1'b0, 32'h0000_010C, 128'h0,
          {32'h108, 32'h104, 32'h100, 32'h10C}, 4, 128'h0,
          128'h0000000A_0000000D_0000000C_0000000B, 1'b0, 6, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();

    // Read with two wait states on beat 1
    set_rd(32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004);
    sl_wait_beat = 1; sl_wait_n = 2;
    issue(1'b0, 32'h0000_0000, 128'h0,
          {32'h00C, 32'h008, 32'h004, 32'h000}, 4, 128'h0,
          128'h10000004_10000003_10000002_10000001, 1'b0, 8, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();
    sl_wait_beat = -1; sl_wait_n = 0;

    // ERROR on beat 1 of a read; beat 2 is presented but never accepted
    set_rd(32'h5555_AAAA, 32'h6666_0001, 32'h6666_0002, 32'h6666_0003);
    sl_err_beat = 1;
    issue(1'b0, 32'h0000_0020, 128'h0,
          {32'h0, 32'h028, 32'h024, 32'h020}, 3, 128'h0,
          {96'h0, 32'h5555_AAAA}, 1'b1, 5, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();
    chk("err_cancelled_beats", q_addr.size(), 1);
    q_addr.delete();
    sl_err_beat = -1;

    // Next request after the error
    issue(1'b1, 32'h0000_0044, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000,
          {32'h040, 32'h04C, 32'h048, 32'h044}, 4,
          {32'hDDDD0000, 32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001},
          {96'h0, 32'h5555_AAAA}, 1'b0, 6, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();

    // Back-to-back: req_valid stays high across both requests
    set_rd(32'h0B0B0000, 32'h0B0B0001, 32'h0B0B0002, 32'h0B0B0003);
    line_b2b = 128'h0B0B0002_0B0B0001_0B0B0000_0B0B0003;
    issue(1'b0, 32'h0000_0034, 128'h0,
          {32'h030, 32'h03C, 32'h038, 32'h034}, 4, 128'h0,
          line_b2b, 1'b0, 6, 1'b1);
    issue(1'b1, 32'h0000_003C, 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000,
          {32'h038, 32'h034, 32'h030, 32'h03C}, 4,
          {32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000, 32'hEEEE0003},
          line_b2b, 1'b0, 6, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();
    chk("b2b_accept_gap", acc_last - acc_prev, 7);

    // Reset asserted while beat 3's address is on the bus
    chk_en = 1'b0;
    issue(1'b1, 32'h0000_0080, 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0,
          128'h0, 0, 128'h0, 128'h0, 1'b0, 0, 1'b0);
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_before = n_rsp_seen;
    chk("abort_in_burst", bus.ahblm_htrans, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("abort_htrans_async", bus.ahblm_htrans, 2'b00);
    chk("abort_req_ready", bus.req_ready, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    q_addr.delete();
    q_wd.delete();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_abort", bus.req_ready, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_rsp", n_rsp_seen, n_before);

    // Fresh write after the abort; rsp_rdata was cleared by reset
    issue(1'b1, 32'h0000_01F0, 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000,
          {32'h1FC, 32'h1F8, 32'h1F4, 32'h1F0}, 4,
          {32'hFFFF0003, 32'hFFFF0002, 32'hFFFF0001, 32'hFFFF0000},
          128'h0, 1'b0, 6, 1'b1);
    bus.req_valid = 1'b0;
    wait_done();
    chk("final_wdata_drained", q_wd.size(), 0);
    chk("final_addr_drained", q_addr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
